// File: rtl/ec_fp_mult_mod_serial_pkg.sv
// rtl/ec_fp_mult_mod_serial_pkg.sv - shared field constants and FSM state type for the serial Fp multiplier
package ec_fp_mult_mod_serial_pkg;

    localparam int EC_DAT_BITS = 256;
    localparam int EC_CTL_BITS = 8;

    // secp256k1 field prime: 2^256 - 2^32 - 977
    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mult_state_e;

    typedef struct packed {
        logic sop;
        logic eop;
        logic err;
    } stream_flags_t;

    function automatic stream_flags_t single_beat_flags(input logic err);
        stream_flags_t f;
        f.sop = 1'b1;
        f.eop = 1'b1;
        f.err = err;
        return f;
    endfunction

endpackage

// File: rtl/ec_fp_mult_mod_serial_if.sv
// rtl/ec_fp_mult_mod_serial_if.sv - valid/ready stream interface carrying data, ctl tag and framing flags
interface if_axi_stream
    import ec_fp_mult_mod_serial_pkg::*;
#(
    parameter int DAT_BITS = EC_DAT_BITS,
    parameter int CTL_BITS = EC_CTL_BITS,
    parameter int MOD_BITS = 1
);
    logic                val;
    logic                rdy;
    logic                sop;
    logic                eop;
    logic                err;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic [MOD_BITS-1:0] mod;

    modport source (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport sink   (input val, sop, eop, err, dat, ctl, mod, output rdy);
    modport master (output val, sop, eop, err, dat, ctl, mod, input rdy);
    modport slave  (input val, sop, eop, err, dat, ctl, mod, output rdy);

endinterface

// File: rtl/ec_fp_mult_mod_serial_dbl_add.sv
// rtl/ec_fp_mult_mod_serial_dbl_add.sv - one MSB-first step of modular multiply: acc = 2*acc (+a) mod p
module ec_fp_mod_dbl_add #(
    parameter int DAT_BITS = 256
) (
    input  logic [DAT_BITS-1:0] acc,
    input  logic [DAT_BITS-1:0] a,
    input  logic                b_bit,
    input  logic [DAT_BITS-1:0] p,
    output logic [DAT_BITS-1:0] acc_nxt
);
    logic [DAT_BITS:0] p_ext;
    logic [DAT_BITS:0] dbl;
    logic [DAT_BITS:0] dbl_red;
    logic [DAT_BITS:0] sum;
    logic [DAT_BITS:0] sum_red;
    logic              unused_msb;

    // acc and a are both < p, so one conditional subtract after each operation keeps the result < p
    always_comb begin
        p_ext   = {1'b0, p};
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= p_ext) ? (dbl - p_ext) : dbl;
        sum     = b_bit ? (dbl_red + {1'b0, a}) : dbl_red;
        sum_red = (sum >= p_ext) ? (sum - p_ext) : sum;
    end

    assign acc_nxt    = sum_red[DAT_BITS-1:0];
    assign unused_msb = sum_red[DAT_BITS];

endmodule

// File: rtl/ec_fp_mult_mod_serial.sv
// rtl/ec_fp_mult_mod_serial.sv - single-slot bit-serial (a*b) mod P responder with tag echo
module ec_fp_mult_mod_serial
    import ec_fp_mult_mod_serial_pkg::*;
#(
    parameter int                  DAT_BITS = EC_DAT_BITS,
    parameter logic [DAT_BITS-1:0] P        = DAT_BITS'(SECP256K1_P),
    parameter int                  CTL_BITS = EC_CTL_BITS
) (
    input  logic          i_clk,
    input  logic          i_rst,
    if_axi_stream.sink    i_mul_if,
    if_axi_stream.source  o_mul_if
);
    localparam int                  CNT_BITS = (DAT_BITS > 1) ? $clog2(DAT_BITS) : 1;
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DAT_BITS - 1);

    mult_state_e         state_q, state_d;
    logic [DAT_BITS-1:0] a_q, a_d;
    logic [DAT_BITS-1:0] b_q, b_d;
    logic [DAT_BITS-1:0] acc_q, acc_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic                err_q, err_d;
    logic                in_rdy_q, in_rdy_d;
    logic                out_val_q, out_val_d;

    logic [DAT_BITS-1:0] req_a;
    logic [DAT_BITS-1:0] req_b;
    logic                op_bad;
    logic [DAT_BITS-1:0] step_acc;
    stream_flags_t       out_flags;
    logic                unused_ok;

    assign req_a  = i_mul_if.dat[0 +: DAT_BITS];
    assign req_b  = i_mul_if.dat[DAT_BITS +: DAT_BITS];
    assign op_bad = (req_a >= P) || (req_b >= P);

    ec_fp_mod_dbl_add #(
        .DAT_BITS (DAT_BITS)
    ) u_step (
        .acc     (acc_q),
        .a       (a_q),
        .b_bit   (b_q[cnt_q]),
        .p       (P),
        .acc_nxt (step_acc)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ctl_q     <= '0;
            err_q     <= 1'b0;
            in_rdy_q  <= 1'b0;
            out_val_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ctl_q     <= ctl_d;
            err_q     <= err_d;
            in_rdy_q  <= in_rdy_d;
            out_val_q <= out_val_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ctl_d     = ctl_q;
        err_d     = err_q;
        in_rdy_d  = in_rdy_q;
        out_val_d = out_val_q;

        case (state_q)
            ST_IDLE: begin
                in_rdy_d = 1'b1;
                if (i_mul_if.val && in_rdy_q) begin
                    a_d      = req_a;
                    b_d      = req_b;
                    ctl_d    = i_mul_if.ctl;
                    acc_d    = '0;
                    cnt_d    = CNT_LAST;
                    in_rdy_d = 1'b0;
                    err_d    = op_bad;
                    // unreduced operands bypass the datapath and report an error with dat=0
                    state_d  = op_bad ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                acc_d = step_acc;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_BITS'(1);
                end
            end
            ST_DONE: begin
                out_val_d = 1'b1;
                if (out_val_q && o_mul_if.rdy) begin
                    out_val_d = 1'b0;
                    in_rdy_d  = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_flags     = single_beat_flags(err_q);
    assign i_mul_if.rdy  = in_rdy_q;
    assign o_mul_if.val  = out_val_q;
    assign o_mul_if.dat  = acc_q;
    assign o_mul_if.ctl  = ctl_q;
    assign o_mul_if.err  = out_flags.err;
    assign o_mul_if.sop  = out_flags.sop;
    assign o_mul_if.eop  = out_flags.eop;
    assign o_mul_if.mod  = '0;

    assign unused_ok = &{1'b0, i_mul_if.sop, i_mul_if.eop, i_mul_if.err, i_mul_if.mod};

endmodule
